// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared types and default geometry for the line-to-burst adaptor.
//   Provides the FSM state enum, default widths, beats per line, the line offset width
//   and the beat index type.
package cacheline_adaptor_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_LINE_W      = 256;
    localparam int DEF_BEAT_W      = 64;
    localparam int DEF_TIMEOUT_CYC = 64;

    localparam int BEATS       = DEF_LINE_W / DEF_BEAT_W;
    localparam int OFFSET_BITS = $clog2(DEF_LINE_W / 8);

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

endpackage

// File: rtl/cacheline_adaptor_line_beat_buf.sv
// line_beat_buf: one line of storage, loadable whole or written/read one beat at a time.
//   clk, rst      clock, asynchronous active-low reset (clears the line)
//   i_load        load i_load_line into the whole buffer (wins over a beat write)
//   i_wr_en       write i_wr_beat into beat slot i_wr_idx
//   i_rd_idx      beat slot presented on o_rd_beat
//   o_line        full buffer contents
module line_beat_buf #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_load_line,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [BEAT_W-1:0] i_wr_beat,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [BEAT_W-1:0] o_rd_beat,
    output logic [LINE_W-1:0] o_line
);

    logic [LINE_W-1:0] r_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_line <= '0;
        else if (i_load)
            r_line <= i_load_line;
        else if (i_wr_en)
            r_line[i_wr_idx*BEAT_W +: BEAT_W] <= i_wr_beat;
    end

    assign o_rd_beat = r_line[i_rd_idx*BEAT_W +: BEAT_W];
    assign o_line    = r_line;

endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns single line read/write ops into 4-beat bursts on a narrow memory port.
//   clk, rst                 clock, asynchronous active-low reset
//   line_addr_i              line-side byte address (offset bits dropped)
//   line_read_i/write_i      line requests, held until line_resp_o; write wins if both
//   line_wdata_i             line to write, beat 0 = bits [BEAT_W-1:0]
//   line_rdata_o             last assembled read line, held until the next read completes
//   line_resp_o              one-cycle completion pulse
//   burst_addr_o             line-aligned burst address
//   burst_read_o/write_o     burst requests, high for the whole burst
//   burst_wdata_o            current write beat
//   burst_rdata_i            read beat, taken when burst_resp_i=1
//   burst_resp_i             beat accepted/delivered this cycle
//   err_o                    sticky stall watchdog error
// Optional: define CACHELINE_ADAPTOR_WATCHDOG_EN to build the stall watchdog; otherwise err_o is 0.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int BEAT_W      = DEF_BEAT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] line_addr_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [ADDR_W-1:0] burst_addr_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i,
    output logic              err_o
);

    localparam int NB = LINE_W / BEAT_W;
    localparam int IW = $clog2(NB);
    localparam int OB = $clog2(LINE_W / 8);

    if (LINE_W != BEAT_W * NB || TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("cacheline_adaptor: LINE_W must be a multiple of BEAT_W and TIMEOUT_CYC positive");
    end

    state_t            r_state, w_next;
    logic [IW-1:0]     r_beat_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_line_rdata;
    logic [LINE_W-1:0] w_buf_line;
    logic [LINE_W-1:0] w_merged;
    logic [BEAT_W-1:0] w_buf_beat;
    logic              w_req;
    logic              w_in_burst;
    logic              w_beat_ok;
    logic              w_last;

    assign w_req      = line_read_i | line_write_i;
    assign w_in_burst = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_beat_ok  = w_in_burst & burst_resp_i;
    assign w_last     = w_beat_ok && (r_beat_cnt == IW'(NB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:               w_next = line_write_i ? WR_BURST : line_read_i ? RD_BURST : IDLE;
            RD_BURST, WR_BURST: w_next = w_last ? DONE : r_state;
            default:            w_next = IDLE;
        endcase
    end

    // The final beat is not yet in the buffer when it arrives, so the completed
    // line is published from the buffer with that beat merged in; this makes
    // line_rdata_o valid in the same cycle as line_resp_o.
    always_comb begin
        w_merged = w_buf_line;
        w_merged[r_beat_cnt*BEAT_W +: BEAT_W] = burst_rdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_beat_cnt   <= '0;
            r_line_rdata <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_beat_cnt <= '0;
                if (w_req)
                    r_addr <= {line_addr_i[ADDR_W-1:OB], {OB{1'b0}}};
            end else if (w_beat_ok) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
            end
            if (r_state == RD_BURST && w_last)
                r_line_rdata <= w_merged;
        end
    end

    line_beat_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IW)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == IDLE && line_write_i),
        .i_load_line (line_wdata_i),
        .i_wr_en     (r_state == RD_BURST && burst_resp_i),
        .i_wr_idx    (r_beat_cnt),
        .i_wr_beat   (burst_rdata_i),
        .i_rd_idx    (r_beat_cnt),
        .o_rd_beat   (w_buf_beat),
        .o_line      (w_buf_line)
    );

    assign line_rdata_o  = r_line_rdata;
    assign line_resp_o   = r_state == DONE;
    assign burst_addr_o  = r_addr;
    assign burst_read_o  = r_state == RD_BURST;
    assign burst_write_o = r_state == WR_BURST;
    assign burst_wdata_o = burst_write_o ? w_buf_beat : '0;

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_idle_cnt;
    logic          r_err;

    // Counts consecutive stalled burst cycles; saturates so it cannot wrap
    // back below the limit while a burst stays stuck.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == IDLE && w_req) || w_beat_ok)
                r_idle_cnt <= '0;
            else if (w_in_burst && r_idle_cnt != CW'(TIMEOUT_CYC))
                r_idle_cnt <= r_idle_cnt + 1'b1;
            if (w_in_burst && !burst_resp_i && r_idle_cnt == CW'(TIMEOUT_CYC - 1))
                r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
